// File: rtl/sweep_pkg.sv
// Shared types and helpers for the pattern_sweep_gen odometer stimulus engine.
// Holds the sweep FSM state encoding and the channel-slice index helper.
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_t;

   // Low bit of channel ch inside a packed bus of w-bit slices.
   function automatic int slice_lo(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/sweep_digit.sv
// One odometer digit: a CNT_W counter that wraps at lim and raises carry on wrap.
// clr and rst both return it to zero; inc advances it.
module sweep_digit #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] lim,
   output logic [CNT_W-1:0] cnt,
   output logic             at_lim,
   output logic             carry
);

   assign at_lim = (cnt == lim);
   assign carry  = inc & at_lim;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= at_lim ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_sweep_gen.sv
// Exhaustive odometer sweep over NUM_CH channels presented on a valid/ready stream.
// Define SWEEP_SIG_EN to fold DUT results into a rotating-XOR signature on sig_o.
module pattern_sweep_gen
   import sweep_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 3,
   parameter int RES_W  = 34
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_CH*CNT_W-1:0]  lim_i,
   output logic [NUM_CH*DATA_W-1:0] pat_o,
   output logic                     pat_valid_o,
   input  logic                     pat_ready_i,
   output logic                     busy_o,
   output logic                     done_o,
   input  logic [RES_W-1:0]         res_i,
   input  logic                     res_valid_i,
   output logic [RES_W-1:0]         sig_o,
   output sweep_state_t             dbg_state_o
);

   // Stream handshake: a pattern transfers on any cycle with pat_valid_o=1 and
   // pat_ready_i=1; while valid and not ready, pat_o is held and valid stays high.

   sweep_state_t              state;
   logic [NUM_CH*CNT_W-1:0]   lim_q;
   logic [CNT_W-1:0]          cnt    [NUM_CH];
   logic [NUM_CH-1:0]         at_lim;
   logic [NUM_CH-1:0]         inc;
   logic [NUM_CH-1:0]         carry;
   logic                      hs;
   logic                      last;
   logic                      clr;
   logic                      unused_carry;

   assign hs           = pat_valid_o & pat_ready_i;
   assign last         = &at_lim;
   assign clr          = (state == ST_IDLE) & start;
   assign dbg_state_o  = state;
   assign unused_carry = carry[0];

   // Channel NUM_CH-1 is the fastest digit; carries ripple toward channel 0.
   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_digit
         if (c == NUM_CH - 1) begin : g_lsd
            assign inc[c] = hs & ~last;
         end else begin : g_inner
            assign inc[c] = carry[c+1];
         end

         sweep_digit #(.CNT_W(CNT_W)) u_digit (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc    (inc[c]),
            .lim    (lim_q[slice_lo(c, CNT_W) +: CNT_W]),
            .cnt    (cnt[c]),
            .at_lim (at_lim[c]),
            .carry  (carry[c])
         );

         assign pat_o[slice_lo(c, DATA_W) +: DATA_W] = DATA_W'(cnt[c]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         lim_q       <= '0;
         pat_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_o <= 1'b0;
               if (start) begin
                  state       <= ST_RUN;
                  lim_q       <= lim_i;
                  pat_valid_o <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            ST_RUN: begin
               if (hs && last) begin
                  state       <= ST_DONE;
                  pat_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               pat_valid_o <= 1'b0;
               busy_o      <= 1'b0;
               done_o      <= 1'b0;
            end
         endcase
      end
   end

`ifdef SWEEP_SIG_EN
   logic [RES_W-1:0] sig;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sig <= '0;
      end else if (res_valid_i) begin
         sig <= {sig[RES_W-2:0], sig[RES_W-1]} ^ res_i;
      end
   end

   assign sig_o = sig;
`else
   logic unused_res;

   assign unused_res = ^{res_i, res_valid_i};
   assign sig_o      = '0;
`endif

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Directed bench for pattern_sweep_gen at default parameters (4 ch x 3-bit counters).
// Expected patterns come from a mixed-radix decode of the pattern index.
module tb_pattern_sweep_gen;
   import sweep_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 3;
   localparam int RES_W  = 34;
   localparam int PW     = NUM_CH * DATA_W;

   logic                    clk;
   logic                    rst;
   logic                    start;
   logic [NUM_CH*CNT_W-1:0] lim_i;
   logic [PW-1:0]           pat_o;
   logic                    pat_valid_o;
   logic                    pat_ready_i;
   logic                    busy_o;
   logic                    done_o;
   logic [RES_W-1:0]        res_i;
   logic                    res_valid_i;
   logic [RES_W-1:0]        sig_o;
   sweep_state_t            dbg_state_o;

   int tests;
   int fails;

   logic [CNT_W-1:0] lim_tb [NUM_CH];
   logic [PW-1:0]    exp_q  [$];

   pattern_sweep_gen #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .RES_W  (RES_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .lim_i       (lim_i),
      .pat_o       (pat_o),
      .pat_valid_o (pat_valid_o),
      .pat_ready_i (pat_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .res_i       (res_i),
      .res_valid_i (res_valid_i),
      .sig_o       (sig_o),
      .dbg_state_o (dbg_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PW-1:0] exp_pat(input int idx);
      int rem;
      int radix;
      logic [PW-1:0] p;
      rem = idx;
      p   = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         radix = int'(lim_tb[c]) + 1;
         p[c*DATA_W +: DATA_W] = 16'(rem % radix);
         rem = rem / radix;
      end
      return p;
   endfunction

   function automatic int total_pats();
      int n;
      n = 1;
      for (int c = 0; c < NUM_CH; c++) n = n * (int'(lim_tb[c]) + 1);
      return n;
   endfunction

   // driver tasks
   task automatic build_exp();
      exp_q.delete();
      for (int i = 0; i < total_pats(); i++) exp_q.push_back(exp_pat(i));
   endtask

   task automatic start_sweep();
      for (int c = 0; c < NUM_CH; c++) lim_i[c*CNT_W +: CNT_W] = lim_tb[c];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic check_next_pat(input string name);
      logic [PW-1:0] e;
      e = exp_q.pop_front();
      tests++;
      if (pat_valid_o !== 1'b1 || pat_o !== e) begin
         fails++;
         $display("FAIL %s: valid=%b pat=%h expected valid=1 pat=%h", name, pat_valid_o, pat_o, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (pat_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          pat_o !== '0 || sig_o !== '0 || dbg_state_o !== ST_IDLE) begin
         fails++;
         $display("FAIL reset: valid=%b busy=%b done=%b pat=%h sig=%h st=%0d expected all zero/IDLE",
                  pat_valid_o, busy_o, done_o, pat_o, sig_o, dbg_state_o);
      end
      start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (pat_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_start_ignored: valid=%b busy=%b expected 0 0", pat_valid_o, busy_o);
      end
   endtask

   task automatic test_small_sweep();
      lim_tb = '{3'd0, 3'd0, 3'd3, 3'd3};
      build_exp();
      pat_ready_i = 1'b1;
      start_sweep();
      for (int k = 0; k < 16; k++) begin
         check_next_pat("small_seq");
         @(posedge clk); #1;
      end
      tests++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || pat_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL small_done: done=%b busy=%b valid=%b expected 1 0 0", done_o, busy_o, pat_valid_o);
      end
      @(posedge clk); #1;
      tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
         fails++;
         $display("FAIL small_after: done=%b busy=%b st=%0d expected 0 0 IDLE", done_o, busy_o, dbg_state_o);
      end
      pat_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] held;
      lim_tb = '{3'd0, 3'd0, 3'd3, 3'd3};
      build_exp();
      pat_ready_i = 1'b1;
      start_sweep();
      for (int k = 0; k < 5; k++) begin
         check_next_pat("bp_pre");
         @(posedge clk); #1;
      end
      held = exp_q[0];
      pat_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tests++;
         if (pat_valid_o !== 1'b1 || pat_o !== held) begin
            fails++;
            $display("FAIL bp_hold: valid=%b pat=%h expected valid=1 pat=%h", pat_valid_o, pat_o, held);
         end
      end
      pat_ready_i = 1'b1;
      for (int k = 5; k < 16; k++) begin
         check_next_pat("bp_post");
         @(posedge clk); #1;
      end
      tests++;
      if (done_o !== 1'b1) begin
         fails++;
         $display("FAIL bp_done: done=%b expected 1", done_o);
      end
      pat_ready_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_lim();
      lim_tb = '{3'd0, 3'd0, 3'd0, 3'd0};
      pat_ready_i = 1'b0;
      start_sweep();
      tests++;
      if (pat_valid_o !== 1'b1 || pat_o !== '0 || busy_o !== 1'b1) begin
         fails++;
         $display("FAIL zero_first: valid=%b pat=%h busy=%b expected 1 0 1", pat_valid_o, pat_o, busy_o);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (pat_valid_o !== 1'b1 || pat_o !== '0 || dbg_state_o !== ST_RUN) begin
         fails++;
         $display("FAIL zero_start_in_run: valid=%b pat=%h st=%0d expected 1 0 RUN", pat_valid_o, pat_o, dbg_state_o);
      end
      pat_ready_i = 1'b1;
      @(posedge clk); #1;
      pat_ready_i = 1'b0;
      tests++;
      if (done_o !== 1'b1 || pat_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL zero_done: done=%b valid=%b expected 1 0", done_o, pat_valid_o);
      end
      @(posedge clk); #1;
      tests++;
      if (done_o !== 1'b0 || pat_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL zero_idle: done=%b valid=%b expected 0 0", done_o, pat_valid_o);
      end
   endtask

   task automatic test_reset_mid();
      lim_tb = '{3'd0, 3'd0, 3'd3, 3'd3};
      build_exp();
      pat_ready_i = 1'b1;
      start_sweep();
      for (int k = 0; k < 5; k++) begin
         check_next_pat("rstmid_pre");
         @(posedge clk); #1;
      end
      rst = 1'b1; pat_ready_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (pat_valid_o !== 1'b0 || pat_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         fails++;
         $display("FAIL rstmid: valid=%b pat=%h done=%b busy=%b expected 0 0 0 0",
                  pat_valid_o, pat_o, done_o, busy_o);
      end
      @(posedge clk); #1;
      tests++;
      if (done_o !== 1'b0 || pat_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_nodone: done=%b valid=%b expected 0 0", done_o, pat_valid_o);
      end
      start_sweep();
      tests++;
      if (pat_valid_o !== 1'b1 || pat_o !== '0) begin
         fails++;
         $display("FAIL rstmid_restart: valid=%b pat=%h expected 1 0", pat_valid_o, pat_o);
      end
      pulse_rst();
   endtask

   task automatic test_signature();
      logic [RES_W-1:0] exp_sig [3];
`ifdef SWEEP_SIG_EN
      exp_sig = '{34'd1, 34'd3, 34'd7};
`else
      exp_sig = '{34'd0, 34'd0, 34'd0};
`endif
      lim_tb = '{3'd0, 3'd0, 3'd0, 3'd0};
      pat_ready_i = 1'b0;
      start_sweep();
      res_i = 34'd1; res_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tests++;
         if (sig_o !== exp_sig[k]) begin
            fails++;
            $display("FAIL sig_step%0d: sig=%h expected %h", k, sig_o, exp_sig[k]);
         end
      end
      res_valid_i = 1'b0; res_i = '0;
      pulse_rst();
      tests++;
      if (sig_o !== '0) begin
         fails++;
         $display("FAIL sig_reset: sig=%h expected 0", sig_o);
      end
   endtask

   task automatic test_full_sweep();
      int done_cnt;
      done_cnt = 0;
      lim_tb = '{3'd7, 3'd7, 3'd7, 3'd7};
      build_exp();
      pat_ready_i = 1'b1;
      start_sweep();
      for (int k = 0; k < 4096; k++) begin
         if (k == 4095) begin
            tests++;
            if (pat_o !== 64'h0007_0007_0007_0007) begin
               fails++;
               $display("FAIL full_last: pat=%h expected 0007000700070007", pat_o);
            end
         end
         check_next_pat("full_seq");
         if (done_o === 1'b1) done_cnt++;
         @(posedge clk); #1;
      end
      for (int j = 0; j < 3; j++) begin
         if (done_o === 1'b1) done_cnt++;
         @(posedge clk); #1;
      end
      tests++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL full_done_count: got %0d expected 1", done_cnt);
      end
      pat_ready_i = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; start = 1'b0; lim_i = '0; pat_ready_i = 1'b0;
      res_i = '0; res_valid_i = 1'b0;
      #1;
      test_reset();
      test_small_sweep();
      test_backpressure();
      test_zero_lim();
      test_reset_mid();
      test_signature();
      test_full_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
